// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// arbitrates the shared memory port, gates decoder write enables and counts retirements.
module cpu_sequencer #(
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dec_ld,
  input  logic                   dec_st,
  input  logic                   dec_wb,
  input  logic                   dec_psw,
  input  logic                   dec_branch,
  input  logic                   take_branch,
  input  logic                   dec_halt,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_sel_data,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   rf_wr_en,
  output logic                   psw_wr_en,
  output logic                   busy,
  output logic                   halted,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t state;
  logic   retire;

  // Branches (including JAL, whose link write happens in EXEC) never visit MEM or WB.
  always_comb begin
    retire = 1'b0;
    unique case (state)
      DECODE:  retire = dec_halt;
      EXEC:    retire = dec_branch | ~(dec_st | dec_ld | dec_wb);
      MEM:     retire = mem_ack & dec_st;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      if (retire)
        instr_count <= instr_count + INSTR_CNT_W'(1);
      unique case (state)
        IDLE:    if (start) state <= FETCH;
        FETCH:   if (mem_ack) state <= DECODE;
        DECODE:  state <= dec_halt ? HALT : EXEC;
        EXEC: begin
          if (dec_branch)
            state <= FETCH;
          else if (dec_st || dec_ld)
            state <= MEM;
          else if (dec_wb)
            state <= WB;
          else
            state <= FETCH;
        end
        MEM:     if (mem_ack) state <= dec_st ? FETCH : WB;
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    rf_wr_en     = 1'b0;
    psw_wr_en    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      EXEC: begin
        psw_wr_en = dec_psw;
        pc_load   = dec_branch & take_branch;
        rf_wr_en  = dec_branch & dec_wb;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = dec_st;
      end
      WB:      rf_wr_en = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer: a per-instruction phase model
// predicts every cycle's strobes and the retired-instruction count.
module tb_cpu_sequencer;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, start, mem_ack;
  logic          dec_ld, dec_st, dec_wb, dec_psw, dec_branch, take_branch, dec_halt;
  logic          mem_req, mem_we, mem_sel_data, ir_load, pc_inc, pc_load;
  logic          rf_wr_en, psw_wr_en, busy, halted;
  logic [CW-1:0] instr_count;

  int passCnt  = 0;
  int totalCnt = 0;
  int expCount = 0;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_e;
  typedef enum int {K_ALU, K_CMP, K_BR, K_JAL, K_LDR, K_STR, K_HLT} kind_e;

  always #5 clk = ~clk;

  cpu_sequencer #(.INSTR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dec_ld(dec_ld), .dec_st(dec_st), .dec_wb(dec_wb), .dec_psw(dec_psw),
    .dec_branch(dec_branch), .take_branch(take_branch), .dec_halt(dec_halt),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_wr_en(rf_wr_en),
    .psw_wr_en(psw_wr_en), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  // Bit order: req we sel ir_load pc_inc pc_load rf_wr psw_wr busy halted
  function automatic logic [9:0] expVec(phase_e ph, logic ack);
    logic [9:0] v;
    v = '0;
    case (ph)
      P_FETCH:  begin v[9] = 1'b1; v[6] = ack; v[5] = ack; v[1] = 1'b1; end
      P_DECODE: v[1] = 1'b1;
      P_EXEC:   begin
                  v[4] = dec_branch & take_branch;
                  v[3] = dec_branch & dec_wb;
                  v[2] = dec_psw;
                  v[1] = 1'b1;
                end
      P_MEM:    begin v[9] = 1'b1; v[8] = dec_st; v[7] = 1'b1; v[1] = 1'b1; end
      P_WB:     begin v[3] = 1'b1; v[1] = 1'b1; end
      P_HALT:   v[0] = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input phase_e ph, input logic ack);
    logic [9:0] obs, exp, mask;
    exp  = expVec(ph, ack);
    mask = exp[9] ? 10'b11_1111_1111 : 10'b10_0111_1111;
    obs  = {mem_req, mem_we, mem_sel_data, ir_load, pc_inc, pc_load,
            rf_wr_en, psw_wr_en, busy, halted};
    totalCnt++;
    assert ((obs & mask) === (exp & mask)) passCnt++;
    else $error("[TB] FAIL %s strobes: observed %b required %b (mask %b)", tag, obs, exp, mask);
    totalCnt++;
    assert (instr_count === CW'(expCount)) passCnt++;
    else $error("[TB] FAIL %s instr_count: observed %0d required %0d", tag, instr_count, expCount);
  endtask

  // One clock cycle: drive ack away from the edge, check, then account for a retirement.
  task automatic applyStimulus(input string tag, input phase_e ph, input logic ack, input bit ret);
    @(negedge clk);
    mem_ack = ack;
    #1;
    checkOutput(tag, ph, ack);
    if (ret) expCount = (expCount + 1) % (1 << CW);
  endtask

  task automatic startRun(input string tag);
    @(negedge clk);
    start   = 1'b1;
    mem_ack = 1'($urandom);
    #1;
    checkOutput(tag, P_IDLE, mem_ack);
  endtask

  task automatic runInstr(input string tag, input kind_e kind, input int fw, input int mw,
                          input bit take, input bit psw, input bit ldToo);
    for (int i = 0; i <= fw; i++)
      applyStimulus({tag, "/fetch"}, P_FETCH, (i == fw), 1'b0);
    @(posedge clk);
    #1;
    start       = 1'($urandom);
    dec_ld      = (kind == K_LDR) || (kind == K_STR && ldToo);
    dec_st      = (kind == K_STR);
    dec_wb      = (kind == K_ALU) || (kind == K_JAL) || (kind == K_LDR);
    dec_psw     = (kind == K_CMP) || (kind == K_ALU && psw);
    dec_branch  = (kind == K_BR) || (kind == K_JAL);
    take_branch = (kind == K_JAL) ? 1'b1 : take;
    dec_halt    = (kind == K_HLT);
    applyStimulus({tag, "/decode"}, P_DECODE, 1'($urandom), kind == K_HLT);
    if (kind == K_HLT) return;
    applyStimulus({tag, "/exec"}, P_EXEC, 1'($urandom),
                  kind == K_CMP || kind == K_BR || kind == K_JAL);
    if (kind == K_LDR || kind == K_STR)
      for (int i = 0; i <= mw; i++)
        applyStimulus({tag, "/mem"}, P_MEM, (i == mw), (kind == K_STR) && (i == mw));
    if (kind == K_ALU || kind == K_LDR)
      applyStimulus({tag, "/wb"}, P_WB, 1'($urandom), 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    dec_ld = 1'b0; dec_st = 1'b0; dec_wb = 1'b0; dec_psw = 1'b0;
    dec_branch = 1'b0; take_branch = 1'b0; dec_halt = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", P_IDLE, mem_ack);
    rst = 1'b0;

    startRun("idle_start");
    runInstr("add", K_ALU, 0, 0, 1'b0, 1'b1, 1'b0);
    runInstr("ldr_wait2", K_LDR, 0, 2, 1'b0, 1'b0, 1'b0);
    runInstr("beq_nt", K_BR, 0, 0, 1'b0, 1'b0, 1'b0);
    runInstr("bal_t", K_BR, 0, 0, 1'b1, 1'b0, 1'b0);
    runInstr("jal", K_JAL, 1, 0, 1'b1, 1'b0, 1'b0);
    runInstr("str_ld", K_STR, 0, 1, 1'b0, 1'b0, 1'b1);
    runInstr("cmp", K_CMP, 2, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++)
      runInstr($sformatf("rnd%0d", n), kind_e'($urandom_range(5, 0)),
               int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
               1'($urandom), 1'($urandom), 1'($urandom));

    runInstr("hlt", K_HLT, 1, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("halt_hold%0d", i), P_HALT, 1'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    checkOutput("halt_rst_cycle", P_HALT, mem_ack);
    @(negedge clk);
    rst = 1'b0;
    expCount = 0;
    #1;
    checkOutput("after_halt_rst", P_IDLE, mem_ack);

    startRun("wrap_start");
    runInstr("wrap1", K_CMP, 0, 0, 1'b0, 1'b0, 1'b0);
    runInstr("wrap2", K_ALU, 1, 0, 1'b0, 1'b0, 1'b0);
    runInstr("wrap3", K_STR, 0, 0, 1'b0, 1'b0, 1'b0);
    runInstr("wrap4", K_LDR, 0, 1, 1'b0, 1'b0, 1'b0);
    runInstr("wrap5", K_BR, 0, 0, 1'b1, 1'b0, 1'b0);

    applyStimulus("fetch_wait", P_FETCH, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    #1;
    checkOutput("fetch_rst_cycle", P_FETCH, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expCount = 0;
    #1;
    checkOutput("after_fetch_rst", P_IDLE, mem_ack);
    applyStimulus("idle_hold", P_IDLE, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
